// File: rtl/bias_seq_ctrl.sv
// Bias buffer sequencer: streams a layer's bias words into the banked buffer,
// then serves per-group bias requests via read-config / bias-valid handshakes.
module bias_seq_ctrl #(
    parameter int X_PE       = 16,
    parameter int ADDR_LEN   = 9,
    parameter int DATA_LEN   = 64,
    parameter int BUFFER_NUM = 8 * X_PE / DATA_LEN
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [ADDR_LEN-1:0]            cfg_base,
    input  logic [ADDR_LEN-1:0]            cfg_grp_m1,
    input  logic                           cfg_usebias,
    input  logic [4:0]                     cfg_shift,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_LEN-1:0]            s_data,
    output logic [DATA_LEN*BUFFER_NUM-1:0] buf_data_wr,
    output logic [ADDR_LEN-1:0]            buf_wr_addr,
    output logic [BUFFER_NUM-1:0]          buf_wr_en,
    output logic                           buf_rd_conf,
    output logic [ADDR_LEN-1:0]            buf_st_rd_addr,
    output logic                           buf_usebias,
    output logic [4:0]                     buf_bias_shift,
    input  logic                           buf_bias_en,
    input  logic                           grp_req,
    output logic                           grp_ack,
    output logic                           done,
    output logic                           busy
);
    localparam int BW = (BUFFER_NUM > 1) ? $clog2(BUFFER_NUM) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_ACK   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]                     state_q, state_d;
    logic [ADDR_LEN-1:0]            base_q, base_d, grp_m1_q, grp_m1_d;
    logic [ADDR_LEN-1:0]            grp_idx_q, grp_idx_d;
    logic [BW-1:0]                  bank_cnt_q, bank_cnt_d;
    logic                           usebias_q, usebias_d;
    logic [4:0]                     shift_q, shift_d;
    logic [ADDR_LEN-1:0]            wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [BUFFER_NUM-1:0]          wr_en_q, wr_en_d;
    logic [DATA_LEN*BUFFER_NUM-1:0] wr_data_q, wr_data_d;
    logic [ADDR_LEN-1:0]            cur_addr;

    // Address wraps naturally by truncation to ADDR_LEN bits.
    assign cur_addr = base_q + grp_idx_q;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        grp_m1_d   = grp_m1_q;
        grp_idx_d  = grp_idx_q;
        bank_cnt_d = bank_cnt_q;
        usebias_d  = usebias_q;
        shift_d    = shift_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = '0;
        case (state_q)
            S_IDLE: if (cfg_valid) begin
                base_d     = cfg_base;
                grp_m1_d   = cfg_grp_m1;
                usebias_d  = cfg_usebias;
                shift_d    = cfg_shift;
                bank_cnt_d = '0;
                grp_idx_d  = '0;
                state_d    = cfg_usebias ? S_LOAD : S_RUN;
            end
            S_LOAD: if (s_valid) begin
                wr_en_d   = BUFFER_NUM'(1) << bank_cnt_q;
                wr_addr_d = cur_addr;
                wr_data_d = {BUFFER_NUM{s_data}};
                if (bank_cnt_q == BW'(BUFFER_NUM - 1)) begin
                    bank_cnt_d = '0;
                    if (grp_idx_q == grp_m1_q) begin
                        grp_idx_d = '0;
                        state_d   = S_RUN;
                    end else begin
                        grp_idx_d = grp_idx_q + ADDR_LEN'(1);
                    end
                end else begin
                    bank_cnt_d = bank_cnt_q + BW'(1);
                end
            end
            S_RUN: if (grp_req) begin
                rd_addr_d = cur_addr;
                state_d   = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            // The rd_conf edge clears the sticky flag, so any high here is fresh.
            S_WAIT:  if (buf_bias_en) state_d = S_ACK;
            S_ACK: begin
                if (grp_idx_q == grp_m1_q) begin
                    state_d = S_DONE;
                end else begin
                    grp_idx_d = grp_idx_q + ADDR_LEN'(1);
                    state_d   = S_RUN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            grp_m1_q   <= '0;
            grp_idx_q  <= '0;
            bank_cnt_q <= '0;
            usebias_q  <= 1'b0;
            shift_q    <= '0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            wr_en_q    <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            grp_m1_q   <= grp_m1_d;
            grp_idx_q  <= grp_idx_d;
            bank_cnt_q <= bank_cnt_d;
            usebias_q  <= usebias_d;
            shift_q    <= shift_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign cfg_ready      = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign s_ready        = (state_q == S_LOAD);
    assign buf_rd_conf    = (state_q == S_ISSUE);
    assign grp_ack        = (state_q == S_ACK);
    assign done           = (state_q == S_DONE);
    assign buf_wr_en      = wr_en_q;
    assign buf_wr_addr    = wr_addr_q;
    assign buf_data_wr    = wr_data_q;
    assign buf_st_rd_addr = rd_addr_q;
    assign buf_usebias    = usebias_q;
    assign buf_bias_shift = shift_q;
endmodule

// File: doc/bias_seq_ctrl.md
# bias_seq_ctrl

Sequencer for the per-layer bias buffer. It loads a layer's bias bytes from a DMA word stream into the banked bias buffer, then serves per-output-channel-group bias requests from the PE array by issuing read configurations and waiting for the buffer's bias-valid flag. It sits between the layer config/DMA front end and the bias buffer, and owns all of the buffer's write and read-config ports.

## Interface
Parameters:
- X_PE, 16, output channels per group
- ADDR_LEN, 9, bias buffer address width
- DATA_LEN, 64, stream word and bank width
- BUFFER_NUM, 8*X_PE/DATA_LEN, number of banks (words per group)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- cfg_valid  in  1  layer config strobe
- cfg_ready  out  1  high only in IDLE
- cfg_base  in  ADDR_LEN  first group address
- cfg_grp_m1  in  ADDR_LEN  group count minus one
- cfg_usebias  in  1  0 = skip load and emit zero bias
- cfg_shift  in  5  bias left shift
- s_valid  in  1  bias stream valid
- s_ready  out  1  bias stream ready
- s_data  in  DATA_LEN  bias word (8 signed bytes)
- buf_data_wr  out  DATA_LEN*BUFFER_NUM  s_data replicated to all banks
- buf_wr_addr  out  ADDR_LEN  write address
- buf_wr_en  out  BUFFER_NUM  one-hot bank write
- buf_rd_conf  out  1  read-config pulse
- buf_st_rd_addr  out  ADDR_LEN  group read address
- buf_usebias  out  1  latched cfg_usebias
- buf_bias_shift  out  5  latched cfg_shift
- buf_bias_en  in  1  buffer bias-valid flag; sticky until the next read-config
- grp_req  in  1  PE array requests the next group's bias
- grp_ack  out  1  one-cycle pulse; bias_out now valid
- done  out  1  one-cycle pulse after the last group
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, LOAD, RUN, ISSUE, WAIT, ACK, DONE.
- IDLE: on cfg_valid, latch base, grp_m1, usebias and shift; clear bank_cnt and grp_idx. Next state is LOAD if usebias=1, else RUN.
- LOAD: s_ready=1. Each accepted beat is written on the next cycle (all write outputs registered):
  - buf_wr_en = 1<<bank_cnt
  - buf_wr_addr = (base+grp_idx) mod 2^ADDR_LEN
  - buf_data_wr = {BUFFER_NUM{s_data}}
  - bank_cnt increments. At BUFFER_NUM-1 it wraps to 0 and grp_idx increments.
  - After the last beat of group grp_m1, clear grp_idx and go to RUN.
  - s_valid low: hold; no write that cycle.
- RUN: on grp_req go to ISSUE. grp_req in any other state is ignored; the requester holds it until grp_ack.
- ISSUE: buf_rd_conf=1 for exactly one cycle; buf_st_rd_addr=(base+grp_idx) mod 2^ADDR_LEN. Next state WAIT.
- WAIT: stay until buf_bias_en=1, then go to ACK. The stale sticky bias_en is cleared by the rd_conf edge, so WAIT never sees it.
- ACK: grp_ack=1. If grp_idx==grp_m1, go to DONE; else increment grp_idx and go to RUN.
- DONE: done=1 for one cycle, then IDLE.
- cfg_valid outside IDLE is ignored (cfg_ready=0).
- Address arithmetic is ADDR_LEN bits and wraps modulo 2^ADDR_LEN.
- Async reset mid-operation: FSM to IDLE, counters cleared, all outputs to reset values. No partial write or rd_conf is emitted after reset.

## Timing
- Reset values:
  - cfg_ready=1
  - s_ready, buf_wr_en, buf_rd_conf, grp_ack, done, busy = 0
  - buf_wr_addr, buf_st_rd_addr, buf_bias_shift, buf_usebias, buf_data_wr = 0
- Load throughput: one beat per cycle. Write latency is 1 cycle after the handshake.
- LOAD→RUN occurs on the edge after the last beat. A grp_req in that first RUN cycle is honoured.
- Request latency, with grp_req high in RUN at cycle t:
  - rd_conf at t+1
  - buf_bias_en expected at t+3
  - grp_ack at t+4
  - next RUN cycle at t+5
- Minimum group period is 5 cycles. grp_req held continuously gives back-to-back groups at that rate.
- done occurs the cycle after the final grp_ack. busy falls the cycle after done.

## Test plan
- usebias=1, base=0, grp_m1=1, BUFFER_NUM=2, 4 stream beats A,B,C,D back-to-back -> writes (addr0,en01,A), (addr0,en10,B), (addr1,en01,C), (addr1,en10,D) on consecutive cycles; then RUN.
- Stream stalls: s_valid toggles 1,0,0,1 -> exactly 2 writes, no write on stall cycles, bank_cnt preserved.
- Two grp_req after load, with the buffer model giving bias_en 2 cycles after rd_conf -> rd_conf addrs 0 then 1; grp_ack at t+4 each time; done 1 cycle after the 2nd ack; back to IDLE with cfg_ready=1.
- usebias=0, grp_m1=0 -> no s_ready and no writes; buf_usebias=0; one rd_conf, one grp_ack, done.
- base=511, grp_m1=1, ADDR_LEN=9 -> group 1 write and read address = 0 (wrap).
- rst_n asserted during WAIT and while cfg_valid is pulsed in RUN -> all outputs return to reset values immediately; the RUN-state cfg is ignored; after release, a new cfg is accepted in IDLE.
